// File: rtl/sodor5_verif_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : sodor5_verif_pkg                                                 |
// | Shared constants, state type and instruction builder for the sodor5        |
// | constrained-random I-type instruction generator.                           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package sodor5_verif_pkg;

  localparam logic [31:0] c_nop           = 32'h00000013;
  localparam logic [6:0]  c_op_imm        = 7'b0010011;
  localparam logic [6:0]  c_op_load       = 7'b0000011;
  localparam logic [31:0] c_lfsr_a_taps   = 32'h80200003;
  localparam logic [31:0] c_lfsr_b_taps   = 32'hA3000000;
  localparam logic [31:0] c_seed_b_xor    = 32'hA5A5A5A5;
  localparam logic [11:0] c_srx_imm_mask  = 12'h41F;
  localparam logic [11:0] c_sll_imm_mask  = 12'h01F;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WARMUP = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } gen_state_t;

  // Shift immediates are masked so SLLI/SRLI/SRAI always decode as legal.
  function automatic logic [31:0] build_instr(input logic [26:0] a, input logic [11:0] b);
    logic [11:0] imm;
    logic [2:0]  f3;
    imm = a[11:0];
    f3  = a[24:22];
    if (a[26]) begin
      if (f3 == 3'd5) begin
        imm = imm & c_srx_imm_mask;
      end else if (f3 == 3'd1) begin
        imm = imm & c_sll_imm_mask;
      end
      return {imm, a[16:12], f3, a[21:17], c_op_imm};
    end
    return {b, a[16:12], a[25], 2'b00, a[21:17], c_op_load};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sodor5_iltype_instr_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : sodor5_iltype_instr_gen_if                                     |
// | Control and instruction stream between the generator and the harness.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface sodor5_iltype_instr_gen_if;
  logic [31:0] seed;
  logic        start;
  logic        stall;
  logic [31:0] instr;
  logic        instr_valid;
  logic [15:0] issued_count;
  logic        done;

  modport master (
    input  seed, start, stall,
    output instr, instr_valid, issued_count, done
  );

  modport slave (
    output seed, start, stall,
    input  instr, instr_valid, issued_count, done
  );
endinterface
`default_nettype wire

// File: rtl/sodor5_lfsr32.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sodor5_lfsr32                                                    |
// | 32-bit right-shifting Galois LFSR with parallel load and step enable.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sodor5_lfsr32 #(
  parameter logic [31:0] TAPS = 32'h80200003
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        step,
  output logic [31:0] value
);

  logic [31:0] r_value;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_value <= 32'd1;
    end else if (load) begin
      r_value <= load_val;
    end else if (step) begin
      r_value <= r_value[0] ? ((r_value >> 1) ^ TAPS) : (r_value >> 1);
    end
  end

  assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/sodor5_iltype_instr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sodor5_iltype_instr_gen                                          |
// | Random RV32I I-type ALU / byte-load stream framed by warm-up and drain     |
// | NOPs, for driving the sodor5 lockstep harness.                             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sodor5_iltype_instr_gen
  import sodor5_verif_pkg::*;
#(
  parameter int NUM_INSTR   = 100,
  parameter int WARMUP_NOPS = 4,
  parameter int DRAIN_NOPS  = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  sodor5_iltype_instr_gen_if.master bus
);

  generate
    if (NUM_INSTR < 1 || NUM_INSTR > 65535) begin : g_bad_num_instr
      $error("NUM_INSTR must be in 1..65535");
    end
    if (WARMUP_NOPS < 1 || WARMUP_NOPS > 65536 || DRAIN_NOPS < 1 || DRAIN_NOPS > 65536) begin : g_bad_nops
      $error("WARMUP_NOPS and DRAIN_NOPS must be in 1..65536");
    end
  endgenerate

  localparam logic [15:0] c_warm_last = 16'(WARMUP_NOPS - 1);
  localparam logic [15:0] c_drain_last = 16'(DRAIN_NOPS - 1);
  localparam logic [15:0] c_num_instr = 16'(NUM_INSTR);

  gen_state_t  r_state;
  logic [15:0] r_phase;
  logic [31:0] r_instr;
  logic        r_valid;
  logic [15:0] r_issued;
  logic        r_done;

  logic [31:0] w_lfsr_a;
  logic [31:0] w_lfsr_b;
  logic [31:0] w_seed_a;
  logic [31:0] w_seed_b_raw;
  logic [31:0] w_seed_b;
  logic        w_load;
  logic        w_step;
  logic [31:0] w_rand_instr;
  logic [15:0] w_issued_inc;
  logic        w_unused_lfsr_bits;

  assign w_seed_a     = (bus.seed == 32'd0) ? 32'd1 : bus.seed;
  assign w_seed_b_raw = w_seed_a ^ c_seed_b_xor;
  assign w_seed_b     = (w_seed_b_raw == 32'd0) ? 32'd1 : w_seed_b_raw;

  assign w_load = !bus.stall && (r_state == ST_IDLE) && bus.start;
  // The LFSRs advance exactly when a random instruction is registered.
  assign w_step = !bus.stall &&
                  (((r_state == ST_WARMUP) && (r_phase == c_warm_last)) ||
                   ((r_state == ST_RUN) && (r_issued != c_num_instr)));

  assign w_rand_instr = build_instr(w_lfsr_a[26:0], w_lfsr_b[11:0]);
  assign w_issued_inc = (r_issued == 16'hFFFF) ? r_issued : r_issued + 16'd1;
  assign w_unused_lfsr_bits = ^{w_lfsr_a[31:27], w_lfsr_b[31:12]};

  sodor5_lfsr32 #(.TAPS(c_lfsr_a_taps)) u_lfsr_a (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (w_load),
    .load_val (w_seed_a),
    .step     (w_step),
    .value    (w_lfsr_a)
  );

  sodor5_lfsr32 #(.TAPS(c_lfsr_b_taps)) u_lfsr_b (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (w_load),
    .load_val (w_seed_b),
    .step     (w_step),
    .value    (w_lfsr_b)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_phase  <= 16'd0;
      r_instr  <= c_nop;
      r_valid  <= 1'b0;
      r_issued <= 16'd0;
      r_done   <= 1'b0;
    end else if (!bus.stall) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state <= ST_WARMUP;
            r_phase <= 16'd0;
          end
        end
        ST_WARMUP: begin
          if (r_phase == c_warm_last) begin
            r_state  <= ST_RUN;
            r_instr  <= w_rand_instr;
            r_valid  <= 1'b1;
            r_issued <= w_issued_inc;
          end else begin
            r_phase <= r_phase + 16'd1;
          end
        end
        ST_RUN: begin
          if (r_issued == c_num_instr) begin
            r_state <= ST_DRAIN;
            r_instr <= c_nop;
            r_valid <= 1'b0;
            r_phase <= 16'd0;
          end else begin
            r_instr  <= w_rand_instr;
            r_issued <= w_issued_inc;
          end
        end
        ST_DRAIN: begin
          if (r_phase == c_drain_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_phase <= r_phase + 16'd1;
          end
        end
        ST_DONE: begin
          r_done <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_instr <= c_nop;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instr        = r_instr;
  assign bus.instr_valid  = r_valid;
  assign bus.issued_count = r_issued;
  assign bus.done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sodor5_iltype_instr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_sodor5_iltype_instr_gen                                       |
// | Randomized self-checking bench against a behavioural stream model.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_sodor5_iltype_instr_gen;

  localparam int NUM_INSTR   = 100;
  localparam int WARMUP_NOPS = 4;
  localparam int DRAIN_NOPS  = 5;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec = 0;
  int   n_fail = 0;
  logic [31:0] exp_q[$];

  sodor5_iltype_instr_gen_if bus();

  sodor5_iltype_instr_gen #(
    .NUM_INSTR   (NUM_INSTR),
    .WARMUP_NOPS (WARMUP_NOPS),
    .DRAIN_NOPS  (DRAIN_NOPS)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] galois(input logic [31:0] v, input logic [31:0] taps);
    return v[0] ? ((v >> 1) ^ taps) : (v >> 1);
  endfunction

  // Expected stream straight from the field rules, as packed integers.
  task automatic build_expected(input logic [31:0] s);
    logic [31:0] a, b, imm, rs1, rd, f3, ins;
    exp_q.delete();
    a = (s == 0) ? 32'd1 : s;
    b = a ^ 32'hA5A5A5A5;
    if (b == 0) b = 32'd1;
    for (int i = 0; i < NUM_INSTR; i++) begin
      imm = a % 4096;
      rs1 = (a / 4096) % 32;
      rd  = (a / 131072) % 32;
      f3  = (a / 4194304) % 8;
      if (((a / 67108864) % 2) == 1) begin
        if (f3 == 5) imm = imm & 32'h41F;
        if (f3 == 1) imm = imm & 32'h01F;
        ins = imm * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + 32'h13;
      end else begin
        ins = (b % 4096) * 1048576 + rs1 * 32768 + ((a / 33554432) % 2) * 4 * 4096
              + rd * 128 + 32'h03;
      end
      exp_q.push_back(ins);
      a = galois(a, 32'h80200003);
      b = galois(b, 32'hA3000000);
    end
  endtask

  task automatic check_legal(input logic [31:0] ins);
    logic [6:0] op;
    logic [2:0] f3;
    op = ins[6:0];
    f3 = ins[14:12];
    check("opcode_legal", {31'd0, (op == 7'b0010011) || (op == 7'b0000011)}, 32'd1);
    if (op == 7'b0000011) check("load_funct3", {31'd0, (f3 == 3'd0) || (f3 == 3'd4)}, 32'd1);
    if (op == 7'b0010011 && f3 == 3'd5) check("srxi_imm", {20'd0, ins[31:20] & 12'hBE0}, 32'd0);
    if (op == 7'b0010011 && f3 == 3'd1) check("slli_imm", {25'd0, ins[31:25]}, 32'd0);
  endtask

  task automatic do_run(input logic [31:0] s, input int stall_at, input int rst_at,
                        output logic [31:0] first_instr);
    int idx, cyc, nops;
    bit fin;
    logic [31:0] held_i;
    logic [15:0] held_c;
    build_expected(s);
    idx = -1; nops = 0; fin = 0; cyc = 1; first_instr = '0;
    bus.seed = s;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.seed = $urandom();
    while (!fin && cyc < 1000) begin
      if (bus.done) begin
        check("drain_nops", nops, DRAIN_NOPS);
        check("run_len", idx + 1, NUM_INSTR);
        check("issued_final", {16'd0, bus.issued_count}, NUM_INSTR);
        check("done_valid", {31'd0, bus.instr_valid}, 32'd0);
        fin = 1;
      end else if (bus.instr_valid) begin
        idx++;
        if (idx == 0) begin
          first_instr = bus.instr;
          check("start_latency", cyc, WARMUP_NOPS + 1);
        end
        if (idx < NUM_INSTR) check("instr", bus.instr, exp_q[idx]);
        else check("run_len", idx, NUM_INSTR - 1);
        check("issued", {16'd0, bus.issued_count}, idx + 1);
        check_legal(bus.instr);
        if (idx == stall_at) begin
          held_i = bus.instr;
          held_c = bus.issued_count;
          bus.stall = 1'b1;
          repeat (3) begin
            tick();
            check("stall_instr", bus.instr, held_i);
            check("stall_issued", {16'd0, bus.issued_count}, {16'd0, held_c});
            check("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
          end
          bus.stall = 1'b0;
        end
        if (idx == rst_at) begin
          reset_n = 1'b0;
          tick();
          reset_n = 1'b1;
          check("rst_instr", bus.instr, NOP);
          check("rst_issued", {16'd0, bus.issued_count}, 32'd0);
          check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
          check("rst_done", {31'd0, bus.done}, 32'd0);
          return;
        end
      end else if (idx < 0) begin
        check("warmup_nop", bus.instr, NOP);
      end else begin
        check("drain_nop", bus.instr, NOP);
        nops++;
      end
      if (!fin) begin
        tick();
        cyc++;
      end
    end
    check("run_timeout", {31'd0, fin}, 32'd1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("done_hold", {31'd0, bus.done}, 32'd1);
    check("done_no_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("done_nop", bus.instr, NOP);
  endtask

  initial begin
    logic [31:0] fi;
    logic [31:0] s;
    bus.seed = '0;
    bus.start = 1'b0;
    bus.stall = 1'b0;

    do_reset();
    check("reset_issued", {16'd0, bus.issued_count}, 32'd0);
    repeat (10) begin
      tick();
      check("idle_instr", bus.instr, NOP);
      check("idle_valid", {31'd0, bus.instr_valid}, 32'd0);
      check("idle_done", {31'd0, bus.done}, 32'd0);
    end

    do_run(32'd0, -1, -1, fi);
    check("zero_seed_first", fi, 32'h5A400003);

    do_reset();
    do_run(32'hA5A5A5A5, -1, -1, fi);

    s = $urandom();
    do_reset();
    do_run(s, 50, -1, fi);

    s = $urandom();
    do_reset();
    do_run(s, -1, 37, fi);
    do_run(s, -1, -1, fi);

    do_reset();
    bus.seed = $urandom();
    bus.start = 1'b1;
    bus.stall = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stall = 1'b0;
    repeat (WARMUP_NOPS + 3) begin
      tick();
      check("start_stall_valid", {31'd0, bus.instr_valid}, 32'd0);
      check("start_stall_instr", bus.instr, NOP);
    end

    for (int r = 0; r < 98; r++) begin
      do_reset();
      do_run($urandom(), -1, -1, fi);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
